dec_msg_builder: RTL and testbench
==================================

# dec_msg_builder

Formats an unsigned binary value into a fixed-length, null-padded decimal ASCII line and hands it to the `print_str` UART string printer. It sits directly upstream of `print_str`: it drives `message` and `dotransmit`, and it watches the printer's `status`. Conversion is a serial double-dabble (shift-add-3) that takes one cycle per input bit. A single instance serves one print channel, for example a telemetry counter.

## Interface
- `VAL_W`, 16, width of the binary input value.
- `NDIGITS`, 5, number of decimal digit characters; must satisfy 10^NDIGITS − 1 < 2^32.
- `STR_LEN`, 13, message length in bytes; must equal the connected `print_str` STR_LEN and be ≥ NDIGITS+2.
- `ACK_TIMEOUT`, 16, number of cycles to wait for the printer to report busy after a pulse.
- `clk` in 1: master clock; all state is on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `value` in VAL_W: number to print; sampled only when it is accepted.
- `value_valid` in 1: single-cycle request to print `value`.
- `printer_busy` in 1: `status` from `print_str`; asynchronous to `clk`, passed through a 2-flop synchronizer (`busy_s`).
- `message` out STR_LEN*8: formatted string, wired to `print_str.message`.
- `dotransmit` out 1: start strobe, wired to `print_str.dotransmit`.
- `busy` out 1: high whenever state ≠ IDLE.
- `dropped` out 1: one-cycle pulse when `value_valid` arrives while `busy` is high.

## Operation
- **Byte order.** The numeric value of `message` is Σ char_k << (8k). char_0 is the low byte and is the first character transmitted.
- **Layout.**
  - char_0 .. char_{NDIGITS−1}: decimal digits, most-significant digit first.
  - char_NDIGITS: 0x0D.
  - char_{NDIGITS+1}: 0x0A.
  - Remaining chars: 0x00.
- **Leading-zero suppression.** Leading zeros are replaced with 0x20. The last digit is always printed, so value 0 gives "    0".
- **Overflow.** If `value` > 10^NDIGITS − 1, every digit char is 0x2A ('*'). CR/LF and padding are unchanged.
- **States.**
  - IDLE: on `value_valid`, latch `value` into the shift register, clear the BCD register, go to CONVERT.
  - CONVERT: run VAL_W iterations. In each iteration, add 3 to every BCD nibble ≥ 5, then shift left by 1 taking the MSB of the value register. Bit counter runs 0..VAL_W−1; after the last iteration go to FORMAT.
  - FORMAT: write `message` from the BCD digits, the overflow compare and the suppression rule. Go to WAIT_IDLE.
  - WAIT_IDLE: stay while `busy_s`=1. When `busy_s`=0, set `dotransmit`=1 and go to PULSE.
  - PULSE: hold `dotransmit`=1 for 2 cycles, then clear it, clear the timeout counter, go to WAIT_ACK.
  - WAIT_ACK: if `busy_s`=1, go to WAIT_DONE. If the counter reaches ACK_TIMEOUT−1, go to IDLE (printer ignored the strobe).
  - WAIT_DONE: when `busy_s`=0, go to IDLE.
- **Message stability.** `message` changes only in FORMAT and is held until the next FORMAT. This guarantees it is stable for at least one full cycle before and throughout the `dotransmit` high time, because `print_str` samples `message` on the `dotransmit` rising edge.
- **Reset.** State=IDLE. `message`=0, `dotransmit`=0, `busy`=0, `dropped`=0. Synchronizer and counters are 0.
- **Reset mid-operation.** Reset aborts immediately and `dotransmit` falls asynchronously. A partially transmitted string is not resent.
- **Requests while busy.** `value_valid` while busy is never queued. It produces `dropped` for 1 cycle, and the conversion in flight is unaffected.
- **IDLE-exit cycle.** A `value_valid` in the same cycle that the block returns to IDLE is dropped, because `busy` is still high on that edge.

## Timing
Edge numbering: edge 0 is the edge that samples `value_valid` in IDLE.
- Edges 1..VAL_W: CONVERT iterations.
- Edge VAL_W+1: FORMAT writes `message`.
- Edge VAL_W+2, if `busy_s`=0: `dotransmit` rises.
- Edge VAL_W+4: `dotransmit` falls.
- With defaults and the printer idle, `dotransmit` is high from edge 18 to edge 20.
- `busy_s` lags `printer_busy` by 2 edges.
- `busy` rises at edge 0 and falls on the edge entering IDLE.
- Minimum request spacing is VAL_W+8 cycles, plus the print time.

## Test plan
- value=1234, printer idle, defaults → `message` low 7 bytes = 20 31 32 33 34 0D 0A (char_0 first), upper 6 bytes 00. `dotransmit` high exactly edges 18–20; `busy` falls after `busy_s` cycles high→low.
- value=0 → "    0\r\n". value=65535 → "65535\r\n". value=100 → "  100\r\n".
- NDIGITS=4, value=12345 → "****\r\n".
- `printer_busy` held high for 50 cycles before the request → `dotransmit` stays 0 until 2 edges after `printer_busy` falls, then pulses for 2 cycles. `message` is unchanged throughout.
- `value_valid` at edges 0 and 5 → `dropped` pulses at edge 5. Output is the edge-0 value only.
- `printer_busy` tied low → WAIT_ACK times out after 16 cycles, return to IDLE. Separately, assert `rst` at edge 8 → all outputs 0 immediately, and a new request converts correctly.

Source files
------------

// File: rtl/dec_msg_builder.sv
// Serial double-dabble formatter that turns a binary value into a fixed-length,
// null-padded decimal ASCII line and strobes it into the print_str UART printer.
module dec_msg_builder #(
  parameter int VAL_W       = 16,
  parameter int NDIGITS     = 5,
  parameter int STR_LEN     = 13,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [VAL_W-1:0]     value,
  input  logic                 value_valid,
  input  logic                 printer_busy,
  output logic [STR_LEN*8-1:0] message,
  output logic                 dotransmit,
  output logic                 busy,
  output logic                 dropped
);

  localparam int BCD_W = 4 * NDIGITS;
  localparam int CNT_W = $clog2(VAL_W + 1);
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [63:0] MAX_DEC = 64'(10 ** NDIGITS) - 64'd1;

  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    FORMAT,
    WAIT_IDLE,
    PULSE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t               state, state_n;
  logic                 busy_meta, busy_s;
  logic [VAL_W-1:0]     shift_reg;
  logic [BCD_W-1:0]     bcd, bcd_adj;
  logic [CNT_W-1:0]     bit_cnt;
  logic [ACK_W-1:0]     ack_cnt;
  logic                 pulse_cnt;
  logic                 ovf;
  logic [STR_LEN*8-1:0] fmt_msg;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_meta <= 1'b0;
      busy_s    <= 1'b0;
    end else begin
      busy_meta <= printer_busy;
      busy_s    <= busy_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (value_valid) state_n = CONVERT;
      CONVERT:   if (bit_cnt == CNT_W'(VAL_W - 1)) state_n = FORMAT;
      FORMAT:    state_n = WAIT_IDLE;
      WAIT_IDLE: if (!busy_s) state_n = PULSE;
      PULSE:     if (pulse_cnt) state_n = WAIT_ACK;
      WAIT_ACK: begin
        if (busy_s)                                 state_n = WAIT_DONE;
        else if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) state_n = IDLE;
      end
      WAIT_DONE: if (!busy_s) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Add-3 correction applied to every BCD nibble before each shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NDIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // char_0 holds the most significant digit; blanks stop at the first nonzero
  // digit, and the final digit is always printed.
  always_comb begin
    logic       lead;
    logic [3:0] digit;
    fmt_msg = '0;
    lead    = 1'b1;
    digit   = 4'd0;
    for (int k = 0; k < NDIGITS; k++) begin
      digit = bcd[4*(NDIGITS-1-k) +: 4];
      if (ovf) begin
        fmt_msg[8*k +: 8] = 8'h2A;
      end else if (lead && (digit == 4'd0) && (k != NDIGITS - 1)) begin
        fmt_msg[8*k +: 8] = 8'h20;
      end else begin
        lead              = 1'b0;
        fmt_msg[8*k +: 8] = {4'h3, digit};
      end
    end
    fmt_msg[8*NDIGITS +: 8]     = 8'h0D;
    fmt_msg[8*(NDIGITS+1) +: 8] = 8'h0A;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg  <= '0;
      bcd        <= '0;
      bit_cnt    <= '0;
      ack_cnt    <= '0;
      pulse_cnt  <= 1'b0;
      ovf        <= 1'b0;
      message    <= '0;
      dotransmit <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      dropped <= value_valid && busy;
      case (state)
        IDLE: begin
          if (value_valid) begin
            shift_reg <= value;
            bcd       <= '0;
            bit_cnt   <= '0;
            ovf       <= (64'(value) > MAX_DEC);
          end
        end
        CONVERT: begin
          bcd       <= (bcd_adj << 1) | BCD_W'(shift_reg[VAL_W-1]);
          shift_reg <= shift_reg << 1;
          bit_cnt   <= bit_cnt + CNT_W'(1);
        end
        FORMAT: message <= fmt_msg;
        WAIT_IDLE: begin
          if (!busy_s) begin
            dotransmit <= 1'b1;
            pulse_cnt  <= 1'b0;
          end
        end
        PULSE: begin
          if (pulse_cnt) begin
            dotransmit <= 1'b0;
            ack_cnt    <= '0;
          end else begin
            pulse_cnt <= 1'b1;
          end
        end
        WAIT_ACK: if (!busy_s) ack_cnt <= ack_cnt + ACK_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_msg_builder.sv
// Self-checking bench for dec_msg_builder: a transaction-level model predicts
// busy/dotransmit/dropped/message every cycle, backed by hand-computed strings.
module tb_dec_msg_builder;

  localparam int VAL_W = 16;
  localparam int ND    = 5;
  localparam int MW    = 104;

  localparam logic [MW-1:0] EXP_1234  = {48'h0, 56'h0A0D3433323120};
  localparam logic [MW-1:0] EXP_0     = {48'h0, 56'h0A0D3020202020};
  localparam logic [MW-1:0] EXP_65535 = {48'h0, 56'h0A0D3533353536};
  localparam logic [MW-1:0] EXP_100   = {48'h0, 56'h0A0D3030312020};
  localparam logic [MW-1:0] EXP_555   = {48'h0, 56'h0A0D3535352020};
  localparam logic [MW-1:0] EXP_4095  = {48'h0, 56'h0A0D3539303420};
  localparam logic [MW-1:0] EXP_STARS = {56'h0, 48'h0A0D2A2A2A2A};

  logic             clk;
  logic             rst;
  logic [VAL_W-1:0] value;
  logic             value_valid;
  logic             v4_valid;
  logic             pb_manual;
  logic             pb_emul;
  logic             printer_busy;
  logic [MW-1:0]    message, message4;
  logic             dotransmit, busy, dropped;
  logic             dt4, busy4, dropped4;

  int n_tests = 0;
  int n_fail  = 0;

  assign printer_busy = pb_manual | pb_emul;

  dec_msg_builder dut (
    .clk          (clk),
    .rst          (rst),
    .value        (value),
    .value_valid  (value_valid),
    .printer_busy (printer_busy),
    .message      (message),
    .dotransmit   (dotransmit),
    .busy         (busy),
    .dropped      (dropped)
  );

  dec_msg_builder #(.VAL_W(16), .NDIGITS(4), .STR_LEN(13), .ACK_TIMEOUT(16)) dut4 (
    .clk          (clk),
    .rst          (rst),
    .value        (value),
    .value_valid  (v4_valid),
    .printer_busy (1'b0),
    .message      (message4),
    .dotransmit   (dt4),
    .busy         (busy4),
    .dropped      (dropped4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Printer stand-in: reports busy for 12 cycles once it sees a start strobe.
  logic emul_on = 1'b1;
  logic dt_prev_e = 1'b0;
  int   emul_cnt = 0;
  assign pb_emul = (emul_cnt != 0);
  always @(posedge clk) begin
    dt_prev_e <= dotransmit;
    if (emul_cnt != 0) emul_cnt <= emul_cnt - 1;
    else if (emul_on && dotransmit && !dt_prev_e) emul_cnt <= 12;
  end

  task automatic checkOutput(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Decimal rendering from place values: a digit is blank while the number is
  // smaller than its place value (units place excepted).
  function automatic logic [MW-1:0] fmtModel(input int unsigned v, input int nd);
    logic [MW-1:0]   m;
    longint unsigned lim;
    longint unsigned place;
    m   = '0;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    for (int k = 0; k < nd; k++) begin
      place = 1;
      for (int j = 0; j < nd - 1 - k; j++) place = place * 10;
      if (longint'(v) >= lim)                m[8*k +: 8] = 8'h2A;
      else if (place > 1 && longint'(v) < place) m[8*k +: 8] = 8'h20;
      else m[8*k +: 8] = 8'(8'h30 + ((longint'(v) / place) % 10));
    end
    m[8*nd +: 8]     = 8'h0D;
    m[8*(nd+1) +: 8] = 8'h0A;
    return m;
  endfunction

  // Transaction model: timeline counted in edges since the request was taken.
  localparam int PH_CONV = 0, PH_WAIT_FREE = 1, PH_STROBE = 2, PH_ACK = 3, PH_PRINTING = 4;
  logic          m_busy = 1'b0, m_dt = 1'b0, m_drop = 1'b0;
  logic [MW-1:0] m_msg = '0;
  logic          pb_d1 = 1'b0, pb_d2 = 1'b0;
  int            phase = 0, t = 0, strobe_edges = 0, ack_edges = 0;
  int unsigned   pend = 0;

  initial begin
    logic bs;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_busy = 1'b0; m_dt = 1'b0; m_drop = 1'b0; m_msg = '0;
        pb_d1 = 1'b0; pb_d2 = 1'b0;
      end else begin
        bs     = pb_d2;
        m_drop = value_valid && m_busy;
        if (!m_busy) begin
          if (value_valid) begin
            m_busy = 1'b1; t = 0; pend = value; phase = PH_CONV;
          end
        end else begin
          case (phase)
            PH_CONV: begin
              t++;
              if (t == VAL_W + 1) begin
                m_msg = fmtModel(pend, ND);
                phase = PH_WAIT_FREE;
              end
            end
            PH_WAIT_FREE: if (!bs) begin m_dt = 1'b1; strobe_edges = 0; phase = PH_STROBE; end
            PH_STROBE: begin
              strobe_edges++;
              if (strobe_edges == 2) begin m_dt = 1'b0; ack_edges = 0; phase = PH_ACK; end
            end
            PH_ACK: begin
              if (bs) phase = PH_PRINTING;
              else begin
                ack_edges++;
                if (ack_edges == 16) m_busy = 1'b0;
              end
            end
            default: if (!bs) m_busy = 1'b0;
          endcase
        end
        pb_d2 = pb_d1;
        pb_d1 = printer_busy;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        checkOutput("busy", MW'(busy), MW'(m_busy));
        checkOutput("dotransmit", MW'(dotransmit), MW'(m_dt));
        checkOutput("dropped", MW'(dropped), MW'(m_drop));
        checkOutput("message", message, m_msg);
      end
    end
  end

  int   cyc = 0, rise_edge = 0, fall_edge = 0, busy_fall_edge = 0, drop_cnt = 0;
  logic dt_q = 1'b0, busy_q = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (dotransmit && !dt_q) rise_edge = cyc;
      if (!dotransmit && dt_q) fall_edge = cyc;
      if (!busy && busy_q) busy_fall_edge = cyc;
      if (dropped) drop_cnt++;
      dt_q   = dotransmit;
      busy_q = busy;
    end
  end

  int acc = 0;
  task automatic applyStimulus(input logic [VAL_W-1:0] v);
    @(negedge clk);
    value       = v;
    value_valid = 1'b1;
    acc         = cyc + 1;
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach_idle", MW'(busy), MW'(1'b0));
  endtask

  initial begin
    int f;
    int n;
    rst = 1'b0; value = '0; value_valid = 1'b0; v4_valid = 1'b0; pb_manual = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_message", message, '0);
    checkOutput("rst_dotransmit", MW'(dotransmit), '0);
    checkOutput("rst_busy", MW'(busy), '0);
    checkOutput("rst_dropped", MW'(dropped), '0);
    rst = 1'b0;

    checkOutput("model_1234", fmtModel(1234, 5), EXP_1234);
    checkOutput("model_0", fmtModel(0, 5), EXP_0);
    checkOutput("model_stars", fmtModel(12345, 4), EXP_STARS);

    applyStimulus(16'd1234);
    waitIdle(200);
    checkOutput("msg_1234", message, EXP_1234);
    checkOutput("dt_rise_edge", MW'(rise_edge - acc), MW'(18));
    checkOutput("dt_fall_edge", MW'(fall_edge - acc), MW'(20));

    applyStimulus(16'd0);
    waitIdle(200);
    checkOutput("msg_0", message, EXP_0);
    applyStimulus(16'd65535);
    waitIdle(200);
    checkOutput("msg_65535", message, EXP_65535);
    applyStimulus(16'd100);
    waitIdle(200);
    checkOutput("msg_100", message, EXP_100);

    @(negedge clk);
    value    = 16'd12345;
    v4_valid = 1'b1;
    @(negedge clk);
    v4_valid = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("msg4_overflow", message4, EXP_STARS);

    pb_manual = 1'b1;
    repeat (50) @(negedge clk);
    applyStimulus(16'd4321);
    repeat (30) @(negedge clk);
    checkOutput("dt_held_while_busy", MW'(dotransmit), '0);
    checkOutput("msg_4321", message, fmtModel(4321, 5));
    pb_manual = 1'b0;
    f = cyc + 1;
    waitIdle(200);
    checkOutput("dt_after_busy_fall", MW'(rise_edge - f), MW'(2));
    checkOutput("dt_pulse_len", MW'(fall_edge - rise_edge), MW'(2));

    drop_cnt = 0;
    applyStimulus(16'd555);
    repeat (4) @(negedge clk);
    value       = 16'd999;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    checkOutput("dropped_edge5", MW'(dropped), MW'(1'b1));
    waitIdle(200);
    checkOutput("drop_count", MW'(drop_cnt), MW'(1));
    checkOutput("msg_555", message, EXP_555);

    emul_on = 1'b0;
    applyStimulus(16'd777);
    waitIdle(200);
    checkOutput("ack_timeout_edge", MW'(busy_fall_edge - acc), MW'(36));
    emul_on = 1'b1;

    applyStimulus(16'd888);
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst8_busy", MW'(busy), '0);
    checkOutput("rst8_message", message, '0);
    checkOutput("rst8_dotransmit", MW'(dotransmit), '0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(16'd2468);
    n = 0;
    while (!dotransmit && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("dt_seen", MW'(dotransmit), MW'(1'b1));
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_pulse_dt", MW'(dotransmit), '0);
    checkOutput("rst_pulse_busy", MW'(busy), '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(16'd4095);
    waitIdle(200);
    checkOutput("msg_4095", message, EXP_4095);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
